sal_dfi_cmd_monitor: RTL and testbench
======================================

// Module: sal_dfi_cmd_monitor
// PURPOSE
//  Receive-side decoder for the DFI control bus driven by the controller's command encoder.
//  Samples cke/cs_n/ras_n/cas_n/we_n/ba/addr each clk and decodes them back into DDR commands.
//  Tracks per-bank open/closed state and checks tRCD/tRP/tRAS/tRFC.
//  Flags protocol violations. Used in the SAL testbench and as optional on-chip assertion logic.
// PARAMETERS
//  NUM_BANKS   8   banks tracked; NUM_BANKS = 2**BA_WIDTH
//  BA_WIDTH    3   bank address width (`DFI_BA_WIDTH)
//  ADDR_WIDTH  16  row/column address width (`DFI_ADDR_WIDTH)
//  CS_WIDTH    1   chip selects (`DFI_CS_WIDTH); only cs_n[0] decoded
//  T_RCD       4   min clks ACT->RD/WR, same bank
//  T_RP        4   min clks PRE->ACT, same bank
//  T_RAS       10  min clks ACT->PRE, same bank
//  T_RFC       20  min clks REF->any ACT
// PORTS
//  clk          in   1           controller clock
//  rst_n        in   1           asynchronous active-low reset
//  dfi_ctrl_if  in   DFI_CTRL_IF.DST  cke, cs_n[CS_WIDTH], ras_n, cas_n, we_n, ba[BA_WIDTH], addr[ADDR_WIDTH], odt (odt unused)
//  err_clr      in   1           clears err_sticky
//  cmd_valid    out  1           decoded non-NOP command this cycle
//  cmd          out  4           cmd_t code
//  cmd_ba       out  BA_WIDTH    bank of cmd
//  cmd_addr     out  ADDR_WIDTH  row (ACT) / column (RD/WR) / addr (PRE, MRS)
//  bank_open    out  NUM_BANKS   1 = bank has an open row
//  err_pulse    out  7           one-clk violation flags, aligned with cmd_valid
//  err_sticky   out  7           OR-accumulated err_pulse
// BEHAVIOUR
//  Reset: all outputs 0 and all bank timers 0. rst_n low mid-sequence aborts immediately; no residual state.
//  Decode (cs_n[0]=0, cke=1), {ras_n,cas_n,we_n}:
//    011 ACT, 101 RD, 100 WR, 010 PRE (addr[10]=1 -> PREA), 001 REF, 000 MRS, 110 ZQ, 111 NOP.
//  cs_n[0]=1 or cke=0 -> NOP. ras/cas/we/ba/addr may be X then and must not reach outputs or state.
//  Latency: 1 clk. Command sampled at edge n appears on cmd* and err_pulse at edge n+1.
//  cmd_valid=0 for NOP; cmd/cmd_ba/cmd_addr then hold their previous values.
//  Bank state: ACT sets bank_open[ba]; PRE clears it; PREA clears all. Updates appear together with cmd_valid.
//  Timing rule, per-bank down-counters: a command k clks after its reference is legal iff k >= T_x.
//    Counters saturate at 0. A new load overrides the remaining count.
//    ACT loads rcd[ba] and ras[ba].
//    PRE loads rp[ba] only if the bank was open; PREA does the same for each open bank.
//    REF loads the global rfc counter.
//  err bits (package constants):
//    0 ACT_OPEN   ACT to a bank already open
//    1 CAS_CLOSED RD/WR to a closed bank
//    2 REF_OPEN   REF while any bank is open
//    3 TRCD, 4 TRP, 5 TRAS, 6 TRFC   ACT during rfc>0 -> TRFC
//  On error, state still updates as the command dictates. ACT to an open bank keeps it open and reloads rcd/ras.
//  PRE to a closed bank: no error, no timer load.
//  Several err bits may assert in the same cycle.
//  err_sticky <= (err_clr ? 0 : err_sticky) | err_pulse. A same-cycle new error survives err_clr.
// STRUCTURE
//  Package sal_dfi_mon_pkg: cmd_t enum (NOP=0, ACT, RD, WR, PRE, PREA, REF, MRS, ZQ), ERR_* bit indices, ERR_W=7.
//  Sub-module sal_bank_timer: one per bank via generate. Holds the open bit plus rcd/rp/ras counters.
//    Inputs: act/pre/cas strobes. Outputs: open plus per-check violation flags.
//  Top: decode, rfc counter, output/error registers.
// TESTING
//  1 Reset, then idle deselect with X on ras/cas/we/addr
//    -> cmd_valid=0, bank_open=0, err_*=0, no X on any output.
//  2 ACT ba=2 row=0x1234 at n, RD ba=2 at n+4
//    -> ACT then RD reported at n+1 and n+5, bank_open=0x04, no error.
//    Repeat with RD at n+3 -> err_pulse[TRCD]=1.
//  3 RD ba=5 with bank closed -> err_pulse=0x02 for 1 clk, err_sticky=0x02.
//    err_clr pulse -> err_sticky=0 on the next clk.
//  4 ACT ba=1, PRE ba=1 (addr[10]=0) at +10, ACT ba=1 at +3 after PRE
//    -> err_pulse[TRP]; PRE at +9 instead -> err_pulse[TRAS].
//    ACT banks 0 and 3, then PREA (addr[10]=1) -> bank_open=0.
//  5 REF while bank 0 open -> err_pulse[REF_OPEN].
//    With all banks closed: REF, then ACT at +19 -> err_pulse[TRFC]; ACT at +20 -> no error.
//  6 rst_n low for 1 clk while banks 0–7 are open with timers running
//    -> bank_open=0; next ACT/RD sequence checks as in test 2.

Source files
------------

// File: rtl/sal_dfi_mon_pkg.sv
// Shared types for the DFI command monitor: decoded command codes and error bit positions.
package sal_dfi_mon_pkg;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_ACT  = 4'd1,
        CMD_RD   = 4'd2,
        CMD_WR   = 4'd3,
        CMD_PRE  = 4'd4,
        CMD_PREA = 4'd5,
        CMD_REF  = 4'd6,
        CMD_MRS  = 4'd7,
        CMD_ZQ   = 4'd8
    } cmd_t;

    localparam int ERR_W          = 7;
    localparam int ERR_ACT_OPEN   = 0;
    localparam int ERR_CAS_CLOSED = 1;
    localparam int ERR_REF_OPEN   = 2;
    localparam int ERR_TRCD       = 3;
    localparam int ERR_TRP        = 4;
    localparam int ERR_TRAS       = 5;
    localparam int ERR_TRFC       = 6;

    // Only meaningful with cs_n[0]=0 and cke=1; the caller masks the deselect case.
    function automatic cmd_t decode_cmd(input logic ras_n, input logic cas_n,
                                        input logic we_n, input logic a10);
        cmd_t c;
        case ({ras_n, cas_n, we_n})
            3'b011:  c = CMD_ACT;
            3'b101:  c = CMD_RD;
            3'b100:  c = CMD_WR;
            3'b010:  c = a10 ? CMD_PREA : CMD_PRE;
            3'b001:  c = CMD_REF;
            3'b000:  c = CMD_MRS;
            3'b110:  c = CMD_ZQ;
            default: c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sal_bank_timer.sv
// Per-bank open bit plus tRCD/tRP/tRAS down-counters; flags are combinational on the strobes.
module sal_bank_timer #(
    parameter int CW    = 5,
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_RAS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic act,
    input  logic pre,
    input  logic cas,
    output logic open,
    output logic act_open_err,
    output logic cas_closed_err,
    output logic trcd_err,
    output logic trp_err,
    output logic tras_err
);

    logic [CW-1:0] rcd, rp, ras;

    assign act_open_err   = act & open;
    assign cas_closed_err = cas & ~open;
    assign trcd_err       = cas & (rcd != '0);
    assign trp_err        = act & (rp != '0);
    assign tras_err       = pre & open & (ras != '0);

    // Loads use T-1: the counter ticks once per clk between the two commands,
    // so a nonzero value at check time means fewer than T clks elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open <= 1'b0;
            rcd  <= '0;
            rp   <= '0;
            ras  <= '0;
        end else begin
            rcd <= (rcd != '0) ? rcd - CW'(1) : '0;
            rp  <= (rp  != '0) ? rp  - CW'(1) : '0;
            ras <= (ras != '0) ? ras - CW'(1) : '0;
            if (act) begin
                open <= 1'b1;
                rcd  <= CW'(T_RCD - 1);
                ras  <= CW'(T_RAS - 1);
            end else if (pre && open) begin
                open <= 1'b0;
                rp   <= CW'(T_RP - 1);
            end
        end
    end

endmodule

// File: rtl/sal_dfi_cmd_monitor.sv
// DFI control-bus monitor: decodes DDR commands, tracks bank state and flags timing/protocol errors.
module sal_dfi_cmd_monitor
    import sal_dfi_mon_pkg::*;
#(
    parameter int BA_WIDTH   = 3,
    parameter int NUM_BANKS  = 2**BA_WIDTH,
    parameter int ADDR_WIDTH = 16,
    parameter int CS_WIDTH   = 1,
    parameter int T_RCD      = 4,
    parameter int T_RP       = 4,
    parameter int T_RAS      = 10,
    parameter int T_RFC      = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dfi_cke,
    input  logic [CS_WIDTH-1:0]   dfi_cs_n,
    input  logic                  dfi_ras_n,
    input  logic                  dfi_cas_n,
    input  logic                  dfi_we_n,
    input  logic [BA_WIDTH-1:0]   dfi_ba,
    input  logic [ADDR_WIDTH-1:0] dfi_addr,
    input  logic                  dfi_odt,
    input  logic                  err_clr,
    output logic                  cmd_valid,
    output logic [3:0]            cmd,
    output logic [BA_WIDTH-1:0]   cmd_ba,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [NUM_BANKS-1:0]  bank_open,
    output logic [ERR_W-1:0]      err_pulse,
    output logic [ERR_W-1:0]      err_sticky
);

    localparam int TMAX = (T_RFC > T_RAS) ? T_RFC : T_RAS;
    localparam int CW   = $clog2(TMAX + 1);

    logic unused_ok;
    assign unused_ok = ^{dfi_odt, dfi_cs_n};

    cmd_t                  dec, s1_cmd;
    logic [BA_WIDTH-1:0]   s1_ba;
    logic [ADDR_WIDTH-1:0] s1_addr;

    // Deselected cycles may carry X on the other pins; keep them out of every register.
    always_comb begin
        dec = CMD_NOP;
        if (!dfi_cs_n[0] && dfi_cke)
            dec = decode_cmd(dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_addr[10]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cmd  <= CMD_NOP;
            s1_ba   <= '0;
            s1_addr <= '0;
        end else begin
            s1_cmd <= dec;
            if (dec != CMD_NOP) begin
                s1_ba   <= dfi_ba;
                s1_addr <= dfi_addr;
            end
        end
    end

    logic                 is_act, is_ref;
    logic [NUM_BANKS-1:0] act_open_v, cas_closed_v, trcd_v, trp_v, tras_v;

    assign is_act = (s1_cmd == CMD_ACT);
    assign is_ref = (s1_cmd == CMD_REF);

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic sel;
        assign sel = (s1_ba == BA_WIDTH'(i));
        sal_bank_timer #(.CW(CW), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)) u_timer (
            .clk            (clk),
            .rst_n          (rst_n),
            .act            (is_act && sel),
            .pre            ((s1_cmd == CMD_PRE && sel) || s1_cmd == CMD_PREA),
            .cas            ((s1_cmd == CMD_RD || s1_cmd == CMD_WR) && sel),
            .open           (bank_open[i]),
            .act_open_err   (act_open_v[i]),
            .cas_closed_err (cas_closed_v[i]),
            .trcd_err       (trcd_v[i]),
            .trp_err        (trp_v[i]),
            .tras_err       (tras_v[i])
        );
    end

    logic [CW-1:0]    rfc;
    logic [ERR_W-1:0] err_next;

    always_comb begin
        err_next                 = '0;
        err_next[ERR_ACT_OPEN]   = |act_open_v;
        err_next[ERR_CAS_CLOSED] = |cas_closed_v;
        err_next[ERR_REF_OPEN]   = is_ref & (|bank_open);
        err_next[ERR_TRCD]       = |trcd_v;
        err_next[ERR_TRP]        = |trp_v;
        err_next[ERR_TRAS]       = |tras_v;
        err_next[ERR_TRFC]       = is_act & (rfc != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfc        <= '0;
            cmd_valid  <= 1'b0;
            cmd        <= '0;
            cmd_ba     <= '0;
            cmd_addr   <= '0;
            err_pulse  <= '0;
            err_sticky <= '0;
        end else begin
            if (is_ref)
                rfc <= CW'(T_RFC - 1);
            else if (rfc != '0)
                rfc <= rfc - CW'(1);
            cmd_valid <= (s1_cmd != CMD_NOP);
            if (s1_cmd != CMD_NOP) begin
                cmd      <= s1_cmd;
                cmd_ba   <= s1_ba;
                cmd_addr <= s1_addr;
            end
            err_pulse  <= err_next;
            err_sticky <= (err_clr ? '0 : err_sticky) | err_next;
        end
    end

endmodule

// File: tb/tb_sal_dfi_cmd_monitor.sv
// Directed bench for sal_dfi_cmd_monitor: hand-computed decode, bank-state and timing-error checks.
module tb_sal_dfi_cmd_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dfi_cke;
    logic [0:0]  dfi_cs_n;
    logic        dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [2:0]  dfi_ba;
    logic [15:0] dfi_addr;
    logic        dfi_odt;
    logic        err_clr;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic [2:0]  cmd_ba;
    logic [15:0] cmd_addr;
    logic [7:0]  bank_open;
    logic [6:0]  err_pulse, err_sticky;

    int ntests = 0;
    int nfail  = 0;

    localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010,
                           REFC = 3'b001, MRS = 3'b000, ZQ = 3'b110;

    sal_dfi_cmd_monitor dut (
        .clk(clk), .rst_n(rst_n), .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n),
        .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
        .dfi_ba(dfi_ba), .dfi_addr(dfi_addr), .dfi_odt(dfi_odt), .err_clr(err_clr),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .bank_open(bank_open), .err_pulse(err_pulse), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic deselect();
        dfi_cs_n  = 1'b1;
        dfi_cke   = 1'b1;
        dfi_ras_n = 1'bx;
        dfi_cas_n = 1'bx;
        dfi_we_n  = 1'bx;
        dfi_ba    = 'x;
        dfi_addr  = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive for one clk, then wait for the 1-clk-latency result; returns at the next drive slot.
    task automatic send(input logic [2:0] rcw, input logic [2:0] ba, input logic [15:0] a);
        dfi_cs_n = 1'b0;
        {dfi_ras_n, dfi_cas_n, dfi_we_n} = rcw;
        dfi_ba   = ba;
        dfi_addr = a;
        @(negedge clk);
        deselect();
        @(negedge clk);
    endtask

    task automatic chk_cmd(input string tag, input logic [3:0] c, input logic [6:0] e);
        chk({tag, ".valid"}, cmd_valid, 1);
        chk({tag, ".cmd"},   cmd, c);
        chk({tag, ".err"},   err_pulse, e);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; err_clr = 1'b0; dfi_odt = 1'b0;
        deselect();
        idle(2);
        chk("rst.valid", cmd_valid, 0);
        chk("rst.open", bank_open, 0);
        chk("rst.sticky", err_sticky, 0);
        rst_n = 1'b1;

        // 1: deselect with X on the bus
        idle(4);
        chk("idle.valid", cmd_valid, 0);
        chk("idle.open", bank_open, 0);
        chk("idle.err", err_pulse, 0);
        chk("idle.noX", $isunknown({cmd_valid, cmd, cmd_ba, cmd_addr, bank_open, err_pulse, err_sticky}), 0);
        send(MRS, 3'd0, 16'h0ABC);
        chk_cmd("mrs", 4'd7, 7'h00);
        chk("mrs.addr", cmd_addr, 16'h0ABC);
        send(ZQ, 3'd0, 16'h0400);
        chk_cmd("zq", 4'd8, 7'h00);

        // 2: ACT/RD spacing 4 ok, spacing 3 -> TRCD
        send(ACT, 3'd2, 16'h1234);
        chk_cmd("act2", 4'd1, 7'h00);
        chk("act2.ba", cmd_ba, 2);
        chk("act2.addr", cmd_addr, 16'h1234);
        chk("act2.open", bank_open, 8'h04);
        idle(2);
        send(RD, 3'd2, 16'h0010);
        chk_cmd("rd2", 4'd2, 7'h00);
        send(WR, 3'd2, 16'h0020);
        chk_cmd("wr2", 4'd3, 7'h00);
        send(ACT, 3'd6, 16'h0001);
        idle(1);
        send(RD, 3'd6, 16'h0008);
        chk_cmd("rd6_trcd", 4'd2, 7'h08);
        chk("rd6.open", bank_open, 8'h44);
        chk("rd6.sticky", err_sticky, 7'h08);
        idle(1);
        chk("nop.valid", cmd_valid, 0);
        chk("nop.hold_cmd", cmd, 4'd2);
        chk("nop.hold_addr", cmd_addr, 16'h0008);
        chk("nop.err", err_pulse, 0);
        idle(8);
        send(PRE, 3'd0, 16'h0400);
        chk_cmd("prea1", 4'd5, 7'h00);
        chk("prea1.open", bank_open, 0);
        pulse_clr();
        chk("clr1.sticky", err_sticky, 0);

        // 3: RD to closed bank, then err_clr
        send(RD, 3'd5, 16'h0000);
        chk_cmd("rd5_closed", 4'd2, 7'h02);
        chk("rd5.sticky", err_sticky, 7'h02);
        idle(1);
        chk("rd5.pulse_drop", err_pulse, 0);
        chk("rd5.sticky_hold", err_sticky, 7'h02);
        pulse_clr();
        chk("clr2.sticky", err_sticky, 0);

        // 4: tRAS/tRP on bank 1, PREA over banks 0 and 3
        send(ACT, 3'd1, 16'h0055);
        chk("act1.open", bank_open, 8'h02);
        idle(8);
        send(PRE, 3'd1, 16'h0000);
        chk_cmd("pre1_ok", 4'd4, 7'h00);
        chk("pre1.open", bank_open, 0);
        idle(1);
        send(ACT, 3'd1, 16'h0055);
        chk_cmd("act1_trp", 4'd1, 7'h10);
        chk("act1b.open", bank_open, 8'h02);
        idle(7);
        send(PRE, 3'd1, 16'h0000);
        chk_cmd("pre1_tras", 4'd4, 7'h20);
        chk("pre1b.open", bank_open, 0);
        send(ACT, 3'd0, 16'h0001);
        send(ACT, 3'd3, 16'h0003);
        chk("act03.open", bank_open, 8'h09);
        idle(8);
        send(PRE, 3'd7, 16'h0400);
        chk_cmd("prea2", 4'd5, 7'h00);
        chk("prea2.open", bank_open, 0);
        chk("t4.sticky", err_sticky, 7'h30);
        pulse_clr();

        // 5: REF with bank open; tRFC boundary
        idle(4);
        send(ACT, 3'd0, 16'h0002);
        send(REFC, 3'd0, 16'h0000);
        chk_cmd("ref_open", 4'd6, 7'h04);
        chk("ref_open.open", bank_open, 8'h01);
        idle(8);
        send(PRE, 3'd0, 16'h0000);
        chk("pre0.err", err_pulse, 0);
        idle(20);
        send(REFC, 3'd0, 16'h0000);
        chk_cmd("ref_ok", 4'd6, 7'h00);
        idle(17);
        send(ACT, 3'd4, 16'h0004);
        chk_cmd("act_trfc19", 4'd1, 7'h40);
        chk("t5.sticky", err_sticky, 7'h44);
        idle(8);
        send(PRE, 3'd4, 16'h0000);
        send(REFC, 3'd0, 16'h0000);
        chk("ref2.err", err_pulse, 0);
        idle(18);
        send(ACT, 3'd4, 16'h0004);
        chk_cmd("act_trfc20", 4'd1, 7'h00);

        // 6: reset with all banks open and timers running
        send(ACT, 3'd0, 16'h0);
        send(ACT, 3'd1, 16'h0);
        send(ACT, 3'd2, 16'h0);
        send(ACT, 3'd3, 16'h0);
        send(ACT, 3'd5, 16'h0);
        send(ACT, 3'd6, 16'h0);
        send(ACT, 3'd7, 16'h0);
        chk("all.open", bank_open, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk("rst2.open_async", bank_open, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2.valid", cmd_valid, 0);
        chk("rst2.sticky", err_sticky, 0);
        send(ACT, 3'd2, 16'h1234);
        chk_cmd("act2_postrst", 4'd1, 7'h00);
        idle(2);
        send(RD, 3'd2, 16'h0010);
        chk_cmd("rd2_postrst", 4'd2, 7'h00);
        send(ACT, 3'd3, 16'h0);
        idle(1);
        send(RD, 3'd3, 16'h0);
        chk_cmd("rd3_postrst_trcd", 4'd2, 7'h08);
        chk("post.open", bank_open, 8'h0C);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
